// File: rtl/board_io_pkg.sv
// -----------------------------------------------------------------------------
// board_io_pkg
// Shared sizes and the debounce state type for the DE2 board input conditioner.
//   NUM_KEYS    : number of push-buttons (KEY pins)
//   NUM_SW      : number of slide switches (sw pins)
//   key_state_t : per-key debounced state (KEY_RELEASED / KEY_PRESSED)
// Optional feature macro used by the files that import this package:
//   KEY_REPEAT_EN (auto-repeat on held keys)
// -----------------------------------------------------------------------------
package board_io_pkg;

  localparam int NUM_KEYS = 4;
  localparam int NUM_SW   = 18;

  typedef enum logic {
    KEY_RELEASED = 1'b0,
    KEY_PRESSED  = 1'b1
  } key_state_t;

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// One push-button: two-flop synchroniser, RELEASED/PRESSED debounce FSM with a
// stability counter, and (when KEY_REPEAT_EN is defined) an auto-repeat timer.
// Ports:
//   clk       in  system clock
//   rst       in  synchronous active-high reset
//   i_key_n   in  raw key pin, active-low
//   o_level   out debounced level, 1 = pressed
//   o_press   out one-cycle pulse per debounced press (plus repeat pulses)
//   o_release out one-cycle pulse per debounced release
// Macro: KEY_REPEAT_EN enables REPEAT_DELAY / REPEAT_PERIOD and the repeat timer.
// -----------------------------------------------------------------------------
module key_debounce
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
`ifdef KEY_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchroniser flops idle at 1 so a reset looks like "released".
  logic r_sync1;
  logic r_sync2;
  logic w_key;

  key_state_t       r_state;
  key_state_t       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_leave;
  logic             w_press_fire;
  logic             w_release_fire;
  logic             w_press_out;
  logic             r_press;
  logic             r_release;

  assign w_key = ~r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  // w_leave: the current sample argues for leaving the present state.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_press_fire   = 1'b0;
    w_release_fire = 1'b0;
    w_leave        = (r_state == KEY_RELEASED) ? w_key : ~w_key;
    if (w_leave) begin
      if (r_cnt == CNT_LAST) begin
        w_cnt_next = '0;
        if (r_state == KEY_RELEASED) begin
          w_state_next = KEY_PRESSED;
          w_press_fire = 1'b1;
        end else begin
          w_state_next   = KEY_RELEASED;
          w_release_fire = 1'b1;
        end
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end else begin
      w_cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= KEY_RELEASED;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_press   <= w_press_out;
      r_release <= w_release_fire;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] r_rep_cnt;
  logic             r_rep_first;
  logic [REP_W-1:0] w_rep_limit;
  logic             w_rep_fire;

  // The timer counts from the edge that produced the press pulse; the first
  // interval is REPEAT_DELAY, later ones REPEAT_PERIOD. A release on the same
  // edge wins so no repeat pulse can coincide with key_release.
  assign w_rep_limit = r_rep_first ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_PERIOD - 1);
  assign w_rep_fire  = (r_state == KEY_PRESSED) && !w_release_fire && (r_rep_cnt == w_rep_limit);
  assign w_press_out = w_press_fire | w_rep_fire;

  always_ff @(posedge clk) begin
    if (rst || (r_state != KEY_PRESSED) || w_release_fire) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else if (w_rep_fire) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b0;
    end else if (r_rep_cnt != w_rep_limit) begin
      r_rep_cnt <= r_rep_cnt + 1'b1;
    end
  end
`else
  assign w_press_out = w_press_fire;
`endif

  assign o_level   = (r_state == KEY_PRESSED);
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/board_input_conditioner.sv
// -----------------------------------------------------------------------------
// board_input_conditioner
// Conditions DE2 push-buttons and slide switches for the counter/display logic.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   KEY[3:0]     in   raw push-buttons, active-low
//   sw[17:0]     in   raw slide switches
//   key_level    out  debounced key level, 1 = pressed
//   key_press    out  one-cycle press pulses (plus auto-repeat when enabled)
//   key_release  out  one-cycle release pulses
//   sw_sync      out  two-flop synchronised switches
//   sw_change    out  one-cycle pulse on any sw_sync bit change
// Macro: KEY_REPEAT_EN enables auto-repeat on held keys.
// -----------------------------------------------------------------------------
module board_input_conditioner
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] KEY,
  input  logic [NUM_SW-1:0]   sw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_SW-1:0]   sw_sync,
  output logic [NUM_SW-1:0]   sw_change
);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("board_input_conditioner: DEBOUNCE_CYCLES must be >= 2 and repeat timings >= 1");
  end

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef KEY_REPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_key (
      .clk      (clk),
      .rst      (rst),
      .i_key_n  (KEY[gi]),
      .o_level  (key_level[gi]),
      .o_press  (key_press[gi]),
      .o_release(key_release[gi])
    );
  end

  logic [NUM_SW-1:0] r_sw_s1;
  logic [NUM_SW-1:0] r_sw_sync;
  logic [NUM_SW-1:0] r_sw_change;

  // sw_change is registered: it is computed from the value sw_sync is about to
  // take (r_sw_s1) against its present value, so it rises on the same edge as
  // sw_sync and equals sw_sync ^ (sw_sync delayed one cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_s1     <= '0;
      r_sw_sync   <= '0;
      r_sw_change <= '0;
    end else begin
      r_sw_s1     <= sw;
      r_sw_sync   <= r_sw_s1;
      r_sw_change <= r_sw_s1 ^ r_sw_sync;
    end
  end

  assign sw_sync   = r_sw_sync;
  assign sw_change = r_sw_change;

endmodule

// File: doc/board_input_conditioner.md
# board_input_conditioner

Synchronises, debounces and edge-detects the DE2 push-buttons and slide switches before they reach the counter/display logic. Raw `KEY[3:0]` (active-low, bouncing) and `sw[17:0]` (asynchronous) enter here. Clean active-high levels and single-cycle event pulses leave here. The counter stage consumes `key_press`/`key_level` and `sw_sync` instead of raw pins.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000 (20 ms @ 50 MHz): consecutive stable cycles required before a key level flips; must be ≥ 2.
- `REPEAT_DELAY`, default 25000000: cycles from a press pulse to the first auto-repeat pulse. Used only with `KEY_REPEAT_EN`.
- `REPEAT_PERIOD`, default 5000000: cycles between later auto-repeat pulses. Used only with `KEY_REPEAT_EN`.

Ports:
- `clk`  in  1  system clock; every flop is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `KEY`  in  4  raw push-buttons, active-low (0 = pressed).
- `sw`  in  18  raw slide switches.
- `key_level`  out  4  debounced key state, active-high (1 = pressed).
- `key_press`  out  4  one-cycle pulse per debounced press, plus auto-repeat pulses when enabled.
- `key_release`  out  4  one-cycle pulse per debounced release.
- `sw_sync`  out  18  switch state after the two-flop synchroniser.
- `sw_change`  out  18  one-cycle pulse on any `sw_sync` bit transition.

## Operation
- **Synchroniser.** Each `KEY`/`sw` bit passes through 2 flops. `KEY` is inverted after the second flop, so internally 1 = pressed.
- **Per-key debounce FSM.** States are RELEASED and PRESSED. A counter `cnt` has width `$clog2(DEBOUNCE_CYCLES+1)`.
  - In RELEASED, a synced input of 1 increments `cnt`; a synced input of 0 clears it. When `cnt == DEBOUNCE_CYCLES-1` and the input is still 1, the FSM enters PRESSED, clears `cnt` and pulses `key_press`.
  - PRESSED mirrors this, using input 0 to move to RELEASED and pulse `key_release`.
  - Any mismatching sample clears `cnt`. A glitch shorter than `DEBOUNCE_CYCLES` cycles therefore never changes `key_level`.
- **Independence.** The 4 keys are fully independent. Several `key_press`/`key_release` bits may pulse in the same cycle.
- **Switches.** Switches are not debounced. `sw_change = sw_sync ^ sw_sync_q`, where `sw_sync_q` is `sw_sync` delayed by one flop.
- **Counter saturation.** Counters never wrap; they stop at the terminal value.
- **Reset.**
  - All outputs go to 0 and all FSMs to RELEASED, with counters at 0.
  - `KEY` synchroniser flops reset to 1 (released); `sw` synchroniser flops and `sw_sync_q` reset to 0.
  - On the first cycle after reset, `sw_change` pulses for any switch that is already high.
  - Reset asserted mid-debounce or mid-repeat discards all progress. A key held through reset is reported as a new press after the full latency.

## Timing
- A key change at `KEY` pins stable from edge t raises `key_level` and pulses `key_press` on edge t+2+`DEBOUNCE_CYCLES`. Release has the same latency.
- `key_press`/`key_release` are high for exactly 1 cycle per event.
- `sw_sync` follows `sw` after 2 edges; `sw_change` is high on the same cycle `sw_sync` changes.
- Every output is a registered flop output. There is no combinational path from an input to an output.

## Configuration
- **`KEY_REPEAT_EN` defined:** each key has a repeat counter.
  - The first repeat pulse on `key_press` occurs `REPEAT_DELAY` cycles after the debounced press pulse, while the key stays PRESSED.
  - Further pulses follow every `REPEAT_PERIOD` cycles.
  - Release, or `rst`, stops repeating immediately and clears the counter. No repeat pulse may coincide with, or follow, the `key_release` pulse.
- **`KEY_REPEAT_EN` undefined:** the repeat logic and its parameters are unused. `key_press` is exactly 1 pulse per press.

## Structure
- Package `board_io_pkg`:
  - `NUM_KEYS = 4`, `NUM_SW = 18`.
  - `typedef enum logic {KEY_RELEASED, KEY_PRESSED} key_state_t`.
- Sub-module `key_debounce`: one key's synchroniser, FSM, counter and optional repeat logic. It is instantiated `NUM_KEYS` times by a generate loop.
- The top level holds the switch synchroniser and the change detector.

## Test plan
All cases use `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY=10`, `REPEAT_PERIOD=3`.
- **Reset state:** `rst`=1 for 3 cycles with `KEY`=4'hF and `sw`=0 → all outputs 0. After release, no pulses are seen for 20 cycles.
- **Clean press/release:** `KEY[0]`=0 from edge 10 and held → `key_level[0]`=1 and a 1-cycle `key_press[0]` on edge 16. Setting `KEY[0]`=1 at edge 30 → 1-cycle `key_release[0]` on edge 36.
- **Bounce rejection:** `KEY[1]` toggles 0/1/0/1 every 2 cycles, then stays at 0 → exactly one `key_press[1]`, 6 cycles after the final stable 0.
- **Simultaneous keys:** `KEY[2]` and `KEY[3]` = 0 on the same edge → both `key_press` bits pulse on the same cycle.
- **Switches:** `sw[17]` goes 0→1 at edge 50 → `sw_sync[17]`=1 and `sw_change[17]` pulses on edge 52.
- **Mid-operation reset and repeat:**
  - `rst` pulse while `KEY[0]` is held with 2 debounce counts done → no press pulse occurs, then a fresh press follows 6 cycles after reset release.
  - With `KEY_REPEAT_EN` defined and the key held, `key_press[0]` pulses at press+10, +13 and +16, then stops on release.
